// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit subtractor cells. half_sub produces a - b for single bits;
// full_sub chains two of them and ORs their borrows (the two borrows can
// never both be 1, so the OR is the exact borrow-out).

module half_sub (
    input  logic A,
    input  logic B,
    output logic Diff,
    output logic Bout
);
    assign Diff = A ^ B;
    assign Bout = ~A & B;
endmodule

module full_sub (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);
    logic d1;
    logic b1;
    logic b2;

    // First stage: A - B
    half_sub u_hs0 (
        .A    (A),
        .B    (B),
        .Diff (d1),
        .Bout (b1)
    );

    // Second stage: (A - B) - Bin
    half_sub u_hs1 (
        .A    (d1),
        .B    (Bin),
        .Diff (Diff),
        .Bout (b2)
    );

    assign Bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts an A/B pair, processes one bit per
// clock LSB-first through a single full_sub cell, and presents
// Diff = (A - B) mod 2^WIDTH and Bout = (A < B) with a valid/ready handshake.
// Diff/Bout are held in dedicated output registers so they stay stable while
// the next operation is in progress and only change on entry to DONE.

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    // Counter is wide enough to hold WIDTH, so it never wraps mid-operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_sr_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             br_reg;
    logic             bout_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;
    logic [CW-1:0]    cnt_reg;

    logic             bit_diff;
    logic             br_next;
    logic [WIDTH-1:0] diff_sr_next;

    full_sub u_full_sub (
        .A    (a_reg[0]),
        .B    (b_reg[0]),
        .Bin  (br_reg),
        .Diff (bit_diff),
        .Bout (br_next)
    );

    // New result bit enters from the MSB side so the LSB lands at bit 0 last.
    assign diff_sr_next = {bit_diff, diff_sr_reg[WIDTH-1:1]};

    // Control FSM and datapath registers, all with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            diff_sr_reg   <= '0;
            diff_reg      <= '0;
            br_reg        <= 1'b0;
            bout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= A;
                        b_reg        <= B;
                        br_reg       <= 1'b0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg       <= a_reg >> 1;
                    b_reg       <= b_reg >> 1;
                    br_reg      <= br_next;
                    diff_sr_reg <= diff_sr_next;
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        diff_reg      <= diff_sr_next;
                        bout_reg      <= br_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign Diff      = diff_reg;
    assign Bout      = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: table of WIDTH=8 vectors, handshake
// corner cases (backpressure, async reset, input changes while busy) and an
// exhaustive WIDTH=4 sweep with random out_ready.

module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Diff;
    logic       Bout;

    logic       in_valid4;
    logic       in_ready4;
    logic [3:0] A4;
    logic [3:0] B4;
    logic       out_valid4;
    logic       out_ready4;
    logic [3:0] Diff4;
    logic       Bout4;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_b;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (A4),
        .B         (B4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .Diff      (Diff4),
        .Bout      (Bout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // One WIDTH=8 operation. With rdy=1 the result is consumed immediately and
    // the return to IDLE is checked; with rdy=0 the task returns in DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb,
                       input string nm, input logic rdy);
        int  n;
        bit  busy_seen;
        @(negedge clk);
        check({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = rdy;
        @(negedge clk);
        in_valid  = 1'b0;
        n         = 0;
        busy_seen = 1'b0;
        while (!out_valid && n < 20) begin
            if (in_ready) busy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'd8);
        check({nm, " in_ready_busy"}, 32'(busy_seen), 32'd0);
        check({nm, " Diff"}, 32'(Diff), 32'(ed));
        check({nm, " Bout"}, 32'(Bout), 32'(eb));
        $display("op %s: A=%02h B=%02h -> Diff=%02h Bout=%0b (latency %0d)", nm, a, b, Diff, Bout, n);
        if (rdy) begin
            @(negedge clk);
            check({nm, " out_valid_drop"}, 32'(out_valid), 32'd0);
            check({nm, " in_ready_back"}, 32'(in_ready), 32'd1);
            check({nm, " Diff_retained"}, 32'(Diff), 32'(ed));
        end
    endtask

    initial begin
        int  n;
        bit  hs;
        logic [7:0] got_d;
        logic       got_b;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        A4         = '0;
        B4         = '0;
        out_ready4 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset Diff", 32'(Diff), 32'd0);
        check("reset Bout", 32'(Bout), 32'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_b, $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: hold off the consumer for 5 cycles
        op8(8'h5A, 8'h3C, 8'h1E, 1'b0, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_valid_hold", 32'(out_valid), 32'd1);
            check("bp in_ready_low", 32'(in_ready), 32'd0);
            check("bp Diff_stable", 32'(Diff), 32'h1E);
            check("bp Bout_stable", 32'(Bout), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        $display("op bp_release: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        // Asynchronous reset after 3 bit edges of SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        A        = 8'hF0;
        B        = 8'h0F;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst Diff", 32'(Diff), 32'd0);
        check("arst Bout", 32'(Bout), 32'd0);
        check("arst in_ready", 32'(in_ready), 32'd1);
        $display("op arst: out_valid=%0b Diff=%02h Bout=%0b", out_valid, Diff, Bout);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst release in_ready", 32'(in_ready), 32'd1);
        op8(8'h01, 8'h01, 8'h00, 1'b0, "post_rst", 1'b1);

        // in_valid held with changing operands during SHIFT
        @(negedge clk);
        in_valid  = 1'b1;
        A         = 8'h35;
        B         = 8'h12;
        out_ready = 1'b1;
        n         = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            A = A + 8'h3B;
            B = B ^ 8'hC7;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("hold latency", 32'(n), 32'd8);
        check("hold Diff", 32'(Diff), 32'h23);
        check("hold Bout", 32'(Bout), 32'd0);
        $display("op hold: Diff=%02h Bout=%0b", Diff, Bout);
        @(negedge clk);
        check("hold idle in_ready", 32'(in_ready), 32'd1);

        // WIDTH=4 exhaustive sweep with random consumer readiness
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                out_ready4 = 1'b0;
                in_valid4  = 1'b1;
                A4         = 4'(a);
                B4         = 4'(b);
                @(negedge clk);
                in_valid4 = 1'b0;
                n = 0;
                while (!out_valid4 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 20) begin
                    check("w4 timeout", 32'(out_valid4), 32'd1);
                end else begin
                    hs = 1'b0;
                    while (!hs) begin
                        got_d      = 8'(Diff4);
                        got_b      = Bout4;
                        out_ready4 = 1'($urandom_range(0, 1));
                        hs         = out_ready4;
                        @(negedge clk);
                        if (!hs) begin
                            if (Diff4 !== got_d[3:0] || Bout4 !== got_b)
                                check("w4 stable", {Diff4, Bout4}, {got_d[3:0], got_b});
                        end
                    end
                    out_ready4 = 1'b0;
                    check($sformatf("w4 %0d-%0d Diff", a, b), 32'(got_d), 32'((a - b) & 15));
                    check($sformatf("w4 %0d-%0d Bout", a, b), 32'(got_b), 32'(a < b));
                    $display("op w4: A=%0h B=%0h -> Diff=%0h Bout=%0b", a, b, got_d[3:0], got_b);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
